// File: rtl/seg7_scan_driver_if.sv
// Bus between the datapath that supplies display values and the scan driver
// that owns the board pins. The datapath side is the master. The scan driver
// is the slave.
interface seg7_scan_driver_if #(
    parameter int N_DIGITS = 4
);
    logic                  load;
    logic [4*N_DIGITS-1:0] value;
    logic [N_DIGITS-1:0]   dp_in;
    logic [N_DIGITS-1:0]   en_mask;
    logic [6:0]            segments;
    logic                  dp;
    logic [N_DIGITS-1:0]   anode;
    logic                  frame_done;

    modport master (
        output load, value, dp_in, en_mask,
        input  segments, dp, anode, frame_done
    );

    modport slave (
        input  load, value, dp_in, en_mask,
        output segments, dp, anode, frame_done
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for N_DIGITS seven-segment digits.
// A prescaler divides clk into digit slots, and an index walks the digits.
// New values are staged in a shadow register. They reach the active register
// only at a frame boundary, so a frame never shows a mix of old and new digits.
// The segment, dp and anode outputs are registered one cycle behind the scan
// position. Polarity is applied at that output register.
module seg7_scan_driver #(
    parameter int N_DIGITS    = 4,
    parameter int DIV         = 1000,
    parameter bit SEG_ACT_LOW = 1'b0,
    parameter bit AN_ACT_LOW  = 1'b1,
    parameter bit BLANK_LEAD  = 1'b1
) (
    input logic               clk,
    input logic               rst,
    seg7_scan_driver_if.slave bus
);

    localparam int CW = $clog2(DIV);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [CW-1:0]       CNT_LAST = CW'(DIV - 1);
    localparam logic [IW-1:0]       IDX_LAST = IW'(N_DIGITS - 1);
    localparam logic [6:0]          SEG_OFF  = {7{SEG_ACT_LOW}};
    localparam logic [N_DIGITS-1:0] AN_OFF   = {N_DIGITS{AN_ACT_LOW}};

    // One complete display image: nibbles, decimal points and enable mask.
    typedef struct packed {
        logic [4*N_DIGITS-1:0] value;
        logic [N_DIGITS-1:0]   dp;
        logic [N_DIGITS-1:0]   en;
    } frame_t;

    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx;
    logic                slot_end;
    logic                frame_end;
    frame_t              in_frame;
    frame_t              shadow;
    frame_t              active;
    logic                pending;
    logic [N_DIGITS-1:0] upper_zero;
    logic [3:0]          sel_nib;
    logic                blank;
    logic [6:0]          seg_next;
    logic                dp_next;
    logic [N_DIGITS-1:0] an_next;

    // Active-high segment pattern for one hex nibble. Bit 0 is segment a.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign slot_end       = (cnt == CNT_LAST);
    assign frame_end      = slot_end && (idx == IDX_LAST);
    assign bus.frame_done = frame_end;
    assign in_frame       = {bus.value, bus.dp_in, bus.en_mask};

    // Prescaler and digit index: each slot lasts DIV cycles, and the index wraps after the last digit.
    // NOTE: state registers use non-blocking assignments so that every always_ff
    // samples the pre-edge values, regardless of the order the blocks are written in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Tear-free update: a load is staged in shadow and promoted at the frame boundary.
    // A load in the boundary cycle itself goes straight to active.
    // NOTE: shadow and active are reset, even though they are plain data. After
    // reset the display must come up blank, not show whatever the flops held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
        end else begin
            if (bus.load) begin
                shadow <= in_frame;
            end
            if (frame_end) begin
                if (bus.load) begin
                    active <= in_frame;
                end else if (pending) begin
                    active <= shadow;
                end
                pending <= 1'b0;
            end else if (bus.load) begin
                pending <= 1'b1;
            end
        end
    end

    // Decode, blanking and anode select for the digit currently being scanned.
    // NOTE: every signal gets a default at the top of always_comb, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        upper_zero = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            upper_zero[i] = ((active.value >> (4 * i)) == '0);
        end
        sel_nib  = active.value[4*int'(idx) +: 4];
        blank    = !active.en[idx] || (BLANK_LEAD && (idx != '0) && upper_zero[idx]);
        seg_next = blank ? 7'h00 : hex_to_seg(sel_nib);
        dp_next  = active.dp[idx] & active.en[idx];
        an_next  = (cnt == '0) ? '0 : (N_DIGITS'(1) << idx);
    end

    // Output register: one cycle behind the scan position, with polarity applied here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.segments <= SEG_OFF;
            bus.dp       <= SEG_ACT_LOW;
            bus.anode    <= AN_OFF;
        end else begin
            bus.segments <= seg_next ^ SEG_OFF;
            bus.dp       <= dp_next ^ SEG_ACT_LOW;
            bus.anode    <= an_next ^ AN_OFF;
        end
    end

endmodule
